// File: rtl/fifo_pkg.sv
// Shared defaults and helpers for the level-tracking synchronous FIFO.
// Level width is sized to hold every occupancy value from 0 to DEPTH.
package fifo_pkg;

    localparam int DSIZE_DEF    = 8;
    localparam int DEPTH_DEF    = 16;
    localparam int AE_LEVEL_DEF = 2;
    localparam int FWFT_DEF     = 1;

    function automatic int lvl_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Single-clock storage array: one synchronous write port, one asynchronous read port.
// Write lands on the clock edge; the read is combinational. There is no flow control and no reset.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter  int DSIZE = DSIZE_DEF,
    parameter  int DEPTH = DEPTH_DEF,
    localparam int AW    = $clog2(DEPTH)
)(
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [DSIZE-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [DSIZE-1:0] rdata_o
);

    logic [DSIZE-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_lvl.sv
// Synchronous FIFO with registered level and flags, plus sticky overflow/underflow.
// Read latency is 0 with FWFT and 1 otherwise; writes when full and reads when empty are dropped and flagged.
module sync_fifo_lvl
    import fifo_pkg::*;
#(
    parameter  int DSIZE    = DSIZE_DEF,
    parameter  int DEPTH    = DEPTH_DEF,
    parameter  int AF_LEVEL = DEPTH - 2,
    parameter  int AE_LEVEL = AE_LEVEL_DEF,
    parameter  int FWFT     = FWFT_DEF,
    localparam int LW       = lvl_width(DEPTH),
    localparam int PW       = $clog2(DEPTH)
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [DSIZE-1:0] wdata,
    input  logic             winc,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             wfull,
    output logic             rempty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [LW-1:0]    level,
    output logic             overflow,
    output logic             underflow
);

    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             wfull_q, wfull_d;
    logic             rempty_q, rempty_d;
    logic             afull_q, afull_d;
    logic             aempty_q, aempty_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             wr_en, rd_en;
    logic [DSIZE-1:0] ram_rdata;

    // Explicit wrap keeps every entry in use when DEPTH is not a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign wr_en = winc && !wfull_q  && !clear;
    assign rd_en = rinc && !rempty_q && !clear;

    always_comb begin
        int lvl_nxt;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        if (clear) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else begin
            if (wr_en) wptr_d = ptr_inc(wptr_q);
            if (rd_en) rptr_d = ptr_inc(rptr_q);
            if (wr_en && !rd_en) begin
                level_d = level_q + LW'(1);
            end else if (!wr_en && rd_en) begin
                level_d = level_q - LW'(1);
            end
            if (winc && wfull_q)  ovf_d = 1'b1;
            if (rinc && rempty_q) udf_d = 1'b1;
        end
        // Flags come from the next level so they line up with level in the same cycle.
        lvl_nxt  = int'(level_d);
        wfull_d  = (lvl_nxt == DEPTH);
        rempty_d = (lvl_nxt == 0);
        afull_d  = (lvl_nxt >= AF_LEVEL);
        aempty_d = (lvl_nxt <= AE_LEVEL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            level_q  <= '0;
            wfull_q  <= 1'b0;
            rempty_q <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            level_q  <= level_d;
            wfull_q  <= wfull_d;
            rempty_q <= rempty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    fifo_ram #(
        .DSIZE (DSIZE),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (wptr_q),
        .wdata_i (wdata),
        .raddr_i (rptr_q),
        .rdata_o (ram_rdata)
    );

    generate
        if (FWFT != 0) begin : g_fwft
            assign rdata = ram_rdata;
        end else begin : g_reg
            logic [DSIZE-1:0] rdata_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata_q <= '0;
                end else if (rd_en) begin
                    rdata_q <= ram_rdata;
                end
            end
            assign rdata = rdata_q;
        end
    endgenerate

    assign level        = level_q;
    assign wfull        = wfull_q;
    assign rempty       = rempty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule
